// File: rtl/dct_2d_seq_ctrl.sv
// 8x8 2D DCT sequencer: row pass through a shared DCT_1D, transpose buffer, column pass.
// Latency: first column valid 2 cycles after the 8th row handshake, then one column per cycle.
// Backpressure: in_ready low while columns drain; out_row/out_valid hold while out_ready is low.
module dct_2d_seq_ctrl #(
  parameter int DATA_W = 8,  // only 8 is supported (DCT_1D is fixed at 8-bit lanes)
  parameter int N      = 8   // only 8 is supported
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W*N-1:0] in_row,
  output logic [DATA_W*N-1:0] dct_in,
  input  logic [DATA_W*N-1:0] dct_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W*N-1:0] out_row,
  output logic                busy,
  output logic                blk_done
);

  localparam int                W       = DATA_W * N;
  localparam int                CNT_W   = $clog2(N);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_ROW  = 2'd0,
    S_LOAD = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  row_cnt;
  logic [CNT_W-1:0]  col_cnt;
  logic [CNT_W-1:0]  col_idx;
  logic [W-1:0]      col_vec;
  logic [W-1:0]      tbuf [N];
  logic              row_acc;

  // Row-pass results, one row-transformed vector per accepted input row
  always_ff @(posedge clk) begin
    if (row_acc) begin
      tbuf[row_cnt] <= dct_out;
    end
  end

  // Gather column col_idx of the transpose buffer; row 0 lands in the top byte
  always_comb begin
    col_vec = '0;
    for (int r = 0; r < N; r++) begin
      col_vec[(N-1-r)*DATA_W +: DATA_W] = tbuf[r][(N-1-int'(col_idx))*DATA_W +: DATA_W];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ROW;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, DCT operand select and input handshake
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    col_idx   = '0;
    unique case (state)
      S_ROW: begin
        in_ready = !rst;
        if (in_valid && !rst && row_cnt == CNT_MAX) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        col_idx   = '0;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        // Prefetch the next column so it is ready the moment the current one is taken;
        // the wrap at col_cnt==7 is harmless because that result is never captured.
        col_idx = col_cnt + CNT_ONE;
        if (out_valid && out_ready && col_cnt == CNT_MAX) begin
          state_nxt = S_ROW;
        end
      end
      default: state_nxt = S_ROW;
    endcase
  end

  assign row_acc = in_valid && in_ready;
  assign dct_in  = (state == S_ROW) ? in_row : col_vec;
  assign busy    = (state != S_ROW) || (row_cnt != '0);

  // Counters, output column register and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      blk_done  <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      unique case (state)
        S_ROW: begin
          if (row_acc) begin
            row_cnt <= (row_cnt == CNT_MAX) ? '0 : row_cnt + CNT_ONE;
          end
        end
        S_LOAD: begin
          out_row   <= dct_out;
          out_valid <= 1'b1;
          col_cnt   <= '0;
        end
        S_OUT: begin
          if (out_valid && out_ready) begin
            if (col_cnt == CNT_MAX) begin
              out_valid <= 1'b0;
              blk_done  <= 1'b1;
            end else begin
              out_row <= dct_out;
              col_cnt <= col_cnt + CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
